// File: rtl/usb_token_scheduler.sv
// Strict-priority owner of the single USB token generator (enum > trans > kbd).
// Define USB_TOKEN_KBD_AGING_EN to promote a starved keyboard engine above trans.
module usb_token_scheduler #(
  parameter int unsigned      CNT_W          = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd20000,
  parameter logic [3:0]       AGE_LIMIT      = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enum_req,
  input  logic [1:0] enum_type,
  input  logic [6:0] enum_addr,
  input  logic [3:0] enum_endp,
  output logic       enum_gnt,
  input  logic       trans_req,
  input  logic [1:0] trans_type,
  input  logic [6:0] trans_addr,
  input  logic [3:0] trans_endp,
  output logic       trans_gnt,
  input  logic       kbd_req,
  input  logic [1:0] kbd_type,
  input  logic [6:0] kbd_addr,
  input  logic [3:0] kbd_endp,
  output logic       kbd_gnt,
  input  logic       eof_guard,
  input  logic       token_busy,
  input  logic       txn_done,
  output logic       token_start,
  output logic [1:0] token_type,
  output logic [6:0] token_addr,
  output logic [3:0] token_endp,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} state_t;

  localparam logic [1:0]       GID_NONE  = 2'd0;
  localparam logic [1:0]       GID_ENUM  = 2'd1;
  localparam logic [1:0]       GID_TRANS = 2'd2;
  localparam logic [1:0]       GID_KBD   = 2'd3;
  localparam logic [CNT_W-1:0] TMO_LAST  = TIMEOUT_CYCLES - 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc_timer(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       type_q, type_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0]       endp_q, endp_d;
  logic [1:0]       gid_q, gid_d;
  logic             enum_gnt_q, enum_gnt_d;
  logic             trans_gnt_q, trans_gnt_d;
  logic             kbd_gnt_q, kbd_gnt_d;
  logic             start_q, start_d;
  logic             tmo_q, tmo_d;
  logic [1:0]       pick;
  logic             kbd_promoted;

`ifdef USB_TOKEN_KBD_AGING_EN
  function automatic logic [3:0] sat_inc_age(input logic [3:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [3:0] kbd_age_q, kbd_age_d;

  assign kbd_promoted = (kbd_age_q >= AGE_LIMIT);

  // Age counts keyboard losses; any keyboard win restarts it.
  always_comb begin
    kbd_age_d = kbd_age_q;
    if (state_q == IDLE) begin
      if (pick == GID_KBD)
        kbd_age_d = '0;
      else if (pick != GID_NONE && kbd_req)
        kbd_age_d = sat_inc_age(kbd_age_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) kbd_age_q <= '0;
    else     kbd_age_q <= kbd_age_d;
  end
`else
  logic unused_age_limit;
  assign kbd_promoted     = 1'b0;
  assign unused_age_limit = ^AGE_LIMIT;
`endif

  always_comb begin
    pick = GID_NONE;
    if (!eof_guard) begin
      if (enum_req)                     pick = GID_ENUM;
      else if (kbd_req && kbd_promoted) pick = GID_KBD;
      else if (trans_req)               pick = GID_TRANS;
      else if (kbd_req)                 pick = GID_KBD;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    type_d      = type_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    gid_d       = gid_q;
    enum_gnt_d  = 1'b0;
    trans_gnt_d = 1'b0;
    kbd_gnt_d   = 1'b0;
    start_d     = 1'b0;
    tmo_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick != GID_NONE) begin
          state_d = ISSUE;
          gid_d   = pick;
          case (pick)
            GID_ENUM: begin
              type_d = enum_type;  addr_d = enum_addr;  endp_d = enum_endp;
              enum_gnt_d = 1'b1;
            end
            GID_TRANS: begin
              type_d = trans_type; addr_d = trans_addr; endp_d = trans_endp;
              trans_gnt_d = 1'b1;
            end
            default: begin
              type_d = kbd_type;   addr_d = kbd_addr;   endp_d = kbd_endp;
              kbd_gnt_d = 1'b1;
            end
          endcase
        end
      end
      ISSUE: begin
        if (!token_busy) begin
          start_d = 1'b1;
          timer_d = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        timer_d = sat_inc_timer(timer_q);
        // A done pulse on the final timeout cycle still counts as success.
        if (txn_done) begin
          state_d = IDLE;
          gid_d   = GID_NONE;
        end else if (timer_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
          gid_d   = GID_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      type_q      <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      gid_q       <= GID_NONE;
      enum_gnt_q  <= 1'b0;
      trans_gnt_q <= 1'b0;
      kbd_gnt_q   <= 1'b0;
      start_q     <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      endp_q      <= endp_d;
      gid_q       <= gid_d;
      enum_gnt_q  <= enum_gnt_d;
      trans_gnt_q <= trans_gnt_d;
      kbd_gnt_q   <= kbd_gnt_d;
      start_q     <= start_d;
      tmo_q       <= tmo_d;
    end
  end

  assign enum_gnt    = enum_gnt_q;
  assign trans_gnt   = trans_gnt_q;
  assign kbd_gnt     = kbd_gnt_q;
  assign token_start = start_q;
  assign token_type  = type_q;
  assign token_addr  = addr_q;
  assign token_endp  = endp_q;
  assign grant_id    = gid_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_usb_token_scheduler.sv
// Directed bench for usb_token_scheduler with a cycle-stamp reference model.
module tb_usb_token_scheduler;
  localparam int T   = 8;
  localparam int AGE = 4;
`ifdef USB_TOKEN_KBD_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enum_req, trans_req, kbd_req;
  logic [1:0] enum_type, trans_type, kbd_type;
  logic [6:0] enum_addr, trans_addr, kbd_addr;
  logic [3:0] enum_endp, trans_endp, kbd_endp;
  logic       enum_gnt, trans_gnt, kbd_gnt;
  logic       eof_guard, token_busy, txn_done;
  logic       token_start, busy, timeout_err;
  logic [1:0] token_type, grant_id;
  logic [6:0] token_addr;
  logic [3:0] token_endp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  usb_token_scheduler #(.CNT_W(16), .TIMEOUT_CYCLES(16'd8), .AGE_LIMIT(4'd4)) dut (
    .clk(clk), .rst(rst),
    .enum_req(enum_req), .enum_type(enum_type), .enum_addr(enum_addr), .enum_endp(enum_endp), .enum_gnt(enum_gnt),
    .trans_req(trans_req), .trans_type(trans_type), .trans_addr(trans_addr), .trans_endp(trans_endp), .trans_gnt(trans_gnt),
    .kbd_req(kbd_req), .kbd_type(kbd_type), .kbd_addr(kbd_addr), .kbd_endp(kbd_endp), .kbd_gnt(kbd_gnt),
    .eof_guard(eof_guard), .token_busy(token_busy), .txn_done(txn_done),
    .token_start(token_start), .token_type(token_type), .token_addr(token_addr), .token_endp(token_endp),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  // Reference model: owner id plus the edge number at which the token went out.
  int         cyc = 0;
  int         start_cyc = -1;
  int         m_owner = 0;
  int         kbd_losses = 0;
  bit         mdl_ok = 1'b0;
  logic [3:1] e_gnt = '0;
  logic       e_start = 1'b0;
  logic       e_tmo = 1'b0;
  logic [1:0] e_type = '0;
  logic [6:0] e_addr = '0;
  logic [3:0] e_endp = '0;

  always @(posedge clk) begin
    int         order [3];
    int         w;
    logic [3:1] req;
    cyc++;
    e_gnt   = '0;
    e_start = 1'b0;
    e_tmo   = 1'b0;
    if (rst) begin
      mdl_ok = 1'b1; m_owner = 0; start_cyc = -1; kbd_losses = 0;
      e_type = '0; e_addr = '0; e_endp = '0;
    end else if (mdl_ok) begin
      if (m_owner == 0) begin
        req   = {kbd_req, trans_req, enum_req};
        order = '{1, 2, 3};
        if (AGING && kbd_losses >= AGE) order = '{1, 3, 2};
        w = 0;
        if (!eof_guard)
          for (int i = 0; i < 3; i++)
            if (w == 0 && req[order[i]]) w = order[i];
        if (w != 0) begin
          m_owner = w; start_cyc = -1; e_gnt[w] = 1'b1;
          case (w)
            1:       begin e_type = enum_type;  e_addr = enum_addr;  e_endp = enum_endp;  end
            2:       begin e_type = trans_type; e_addr = trans_addr; e_endp = trans_endp; end
            default: begin e_type = kbd_type;   e_addr = kbd_addr;   e_endp = kbd_endp;   end
          endcase
          if (w == 3)       kbd_losses = 0;
          else if (kbd_req) kbd_losses = (kbd_losses < 15) ? kbd_losses + 1 : 15;
        end
      end else if (start_cyc < 0) begin
        if (!token_busy) begin e_start = 1'b1; start_cyc = cyc; end
      end else if (txn_done) begin
        m_owner = 0;
      end else if (cyc - start_cyc == T) begin
        e_tmo = 1'b1; m_owner = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      n_cmp++;
      if ({enum_gnt, trans_gnt, kbd_gnt} !== {e_gnt[1], e_gnt[2], e_gnt[3]} ||
          token_start !== e_start || timeout_err !== e_tmo ||
          grant_id !== m_owner[1:0] || busy !== (m_owner != 0) ||
          token_type !== e_type || token_addr !== e_addr || token_endp !== e_endp) begin
        n_bad++;
        $display("FAIL model cycle %0d: got gnt=%b%b%b start=%b tmo=%b gid=%0d busy=%b tok=%0d/%0d/%0d required gnt=%b%b%b start=%b tmo=%b gid=%0d busy=%b tok=%0d/%0d/%0d",
                 cyc, enum_gnt, trans_gnt, kbd_gnt, token_start, timeout_err, grant_id, busy,
                 token_type, token_addr, token_endp, e_gnt[1], e_gnt[2], e_gnt[3], e_start, e_tmo,
                 m_owner, (m_owner != 0), e_type, e_addr, e_endp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Requesters drop req on the cycle they see their grant.
  logic [3:1] seen;
  task automatic step();
    @(negedge clk);
    seen = {kbd_gnt, trans_gnt, enum_gnt};
    if (enum_gnt)  enum_req  = 1'b0;
    if (trans_gnt) trans_req = 1'b0;
    if (kbd_gnt)   kbd_req   = 1'b0;
  endtask

  task automatic wait_gnt(input int id, input string nm);
    int k = 0;
    do begin step(); k++; end while (!seen[id] && k < 40);
    chk(nm, {31'd0, seen[id]}, 32'd1);
  endtask

  task automatic wait_start(input string nm);
    int k = 0;
    do begin step(); k++; end while (token_start !== 1'b1 && k < 40);
    chk(nm, {31'd0, token_start}, 32'd1);
  endtask

  task automatic finish_txn(input string nm);
    wait_start(nm);
    step(); txn_done = 1'b1;
    step(); txn_done = 1'b0;
  endtask

  int cnt;

  initial begin
    rst = 1'b1; eof_guard = 1'b0; token_busy = 1'b0; txn_done = 1'b0;
    enum_req = 1'b0; trans_req = 1'b0; kbd_req = 1'b0;
    enum_type = '0; enum_addr = '0; enum_endp = '0;
    trans_type = '0; trans_addr = '0; trans_endp = '0;
    kbd_type = '0; kbd_addr = '0; kbd_endp = '0;
    step(); step();
    rst = 1'b0;
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset grant_id", {30'd0, grant_id}, 0);
    chk("reset token_start", {31'd0, token_start}, 0);

    // all three request together
    enum_type = 2'd2; enum_addr = 7'd0; enum_endp = 4'd0;
    trans_type = 2'd1; trans_addr = 7'd5; trans_endp = 4'd1;
    kbd_type = 2'd1; kbd_addr = 7'd9; kbd_endp = 4'd2;
    enum_req = 1'b1; trans_req = 1'b1; kbd_req = 1'b1;
    step();
    chk("simul enum_gnt", {31'd0, enum_gnt}, 1);
    chk("simul trans_gnt", {31'd0, trans_gnt}, 0);
    chk("simul grant_id", {30'd0, grant_id}, 1);
    enum_addr = 7'h55;
    step();
    chk("simul token_start", {31'd0, token_start}, 1);
    chk("simul token_addr", {25'd0, token_addr}, 0);
    chk("simul token_endp", {28'd0, token_endp}, 0);
    chk("simul token_type", {30'd0, token_type}, 2);
    step(); txn_done = 1'b1;
    step(); txn_done = 1'b0;
    chk("enum done busy", {31'd0, busy}, 0);
    step();
    chk("trans next gnt", {31'd0, trans_gnt}, 1);
    chk("trans next grant_id", {30'd0, grant_id}, 2);
    finish_txn("trans start");
    wait_gnt(3, "kbd after trans");
    finish_txn("kbd start");

    // guard window
    eof_guard = 1'b1; kbd_req = 1'b1; kbd_addr = 7'd3;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      trans_req = (i >= 10 && i < 14);
      step();
      if (|seen) cnt++;
    end
    chk("guard grants", cnt, 0);
    eof_guard = 1'b0;
    step();
    chk("guard release kbd_gnt", {31'd0, kbd_gnt}, 1);
    finish_txn("guard kbd start");

    // generator busy after grant; stray txn_done in ISSUE
    token_busy = 1'b1; trans_req = 1'b1; trans_addr = 7'd17;
    step();
    chk("busy trans_gnt", {31'd0, trans_gnt}, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      txn_done = (i == 5);
      step();
      if (token_start) cnt++;
    end
    txn_done = 1'b0;
    chk("busy held start count", cnt, 0);
    chk("busy held busy", {31'd0, busy}, 1);
    token_busy = 1'b0;
    step();
    chk("busy release start", {31'd0, token_start}, 1);
    chk("busy token_addr", {25'd0, token_addr}, 17);
    step();
    chk("busy single pulse", {31'd0, token_start}, 0);
    txn_done = 1'b1; step(); txn_done = 1'b0;

    // timeout, then done on the timeout cycle
    enum_req = 1'b1; enum_addr = 7'd1;
    wait_gnt(1, "tmo enum gnt");
    wait_start("tmo start");
    repeat (T - 1) step();
    chk("tmo not early", {31'd0, timeout_err}, 0);
    step();
    chk("tmo pulse", {31'd0, timeout_err}, 1);
    chk("tmo busy", {31'd0, busy}, 0);
    chk("tmo grant_id", {30'd0, grant_id}, 0);
    step();
    enum_req = 1'b1;
    wait_gnt(1, "tmo2 enum gnt");
    wait_start("tmo2 start");
    repeat (T - 1) step();
    txn_done = 1'b1; step(); txn_done = 1'b0;
    chk("done beats tmo", {31'd0, timeout_err}, 0);
    chk("done beats tmo busy", {31'd0, busy}, 0);

    // reset during WAIT_DONE
    trans_req = 1'b1;
    wait_gnt(2, "rst trans gnt");
    wait_start("rst start");
    step(); rst = 1'b1;
    step();
    chk("mid rst busy", {31'd0, busy}, 0);
    chk("mid rst grant_id", {30'd0, grant_id}, 0);
    chk("mid rst token_addr", {25'd0, token_addr}, 0);
    step(); rst = 1'b0;
    cnt = 0;
    repeat (20) begin step(); if (token_start || timeout_err || (|seen)) cnt++; end
    chk("post rst activity", cnt, 0);

    // trans re-requests each round while kbd waits
    kbd_req = 1'b1;
    for (int r = 0; r < 5; r++) begin
      int k = 0;
      trans_req = 1'b1;
      do begin step(); k++; end while (seen == 3'b000 && k < 40);
      chk($sformatf("aging round %0d winner", r), {29'd0, seen},
          (AGING && r == 4) ? 32'd4 : 32'd2);
      finish_txn($sformatf("aging round %0d start", r));
    end
    for (int r = 0; r < 2; r++) begin
      if (trans_req || kbd_req) begin
        int k = 0;
        do begin step(); k++; end while (seen == 3'b000 && k < 40);
        finish_txn("drain start");
      end
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time %0t required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usb_token_scheduler.md
Name: usb_token_scheduler

Overview:
- Sequential scheduler that owns the single USB token generator and shares it between the enumerator, transaction engine and keyboard engine.
- Uses a request/grant handshake and strict priority: enumerator > transaction > keyboard.
- Holds the token generator for one full transaction, from token issue until the transaction completes or times out.
- Blocks new tokens during the end-of-frame guard window. Sits between the three host controllers and usb_token_gen.

Parameters:
- TIMEOUT_CYCLES, 16'd20000: max cycles in WAIT_DONE before forced release.
- CNT_W, 16: width of the timeout counter.
- AGE_LIMIT, 4'd4: keyboard loss count that triggers promotion; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enum_req  in  1  enumerator request, held until enum_gnt
- enum_type  in  2  enumerator token type
- enum_addr  in  7  enumerator device address
- enum_endp  in  4  enumerator endpoint
- enum_gnt  out  1  1-cycle grant pulse to enumerator
- trans_req / trans_type / trans_addr / trans_endp / trans_gnt: same as enum_*, transaction engine
- kbd_req / kbd_type / kbd_addr / kbd_endp / kbd_gnt: same as enum_*, keyboard engine
- eof_guard  in  1  1 = inside end-of-frame guard; no new grants
- token_busy  in  1  token generator busy shifting a packet
- txn_done  in  1  1-cycle pulse: transaction finished (handshake/data/timeout seen)
- token_start  out  1  1-cycle pulse to token generator
- token_type  out  2  latched token type
- token_addr  out  7  latched device address
- token_endp  out  4  latched endpoint
- grant_id  out  2  owner: 0 none, 1 enum, 2 trans, 3 kbd
- busy  out  1  1 whenever state != IDLE
- timeout_err  out  1  1-cycle pulse on forced release

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, timer=0, all outputs 0, all gnt=0, grant_id=0. Applies mid-transaction too: any pending token_start is suppressed and no grant or error pulse follows.
- State machine: IDLE -> ISSUE -> WAIT_DONE -> IDLE.
- IDLE, entry: when eof_guard=0 and any req=1, pick the highest-priority requester. Then, at the next edge:
  - latch its type/addr/endp into the token_* regs;
  - set grant_id;
  - pulse its gnt for exactly one cycle;
  - enter ISSUE.
- IDLE, no grant: if eof_guard=1 or no req, stay in IDLE; token_* regs keep their last values.
- ISSUE: while token_busy=1, wait. When token_busy=0, pulse token_start for one cycle, clear timer, enter WAIT_DONE.
- WAIT_DONE: timer increments each cycle, saturating at all-ones.
  - txn_done=1: enter IDLE and clear grant_id.
  - timer==TIMEOUT_CYCLES-1 with txn_done=0: pulse timeout_err, enter IDLE, clear grant_id.
  - txn_done and timeout in the same cycle: done wins, no timeout_err.
- txn_done outside WAIT_DONE is ignored.
- Latency: req sampled at edge N -> gnt high in cycle N+1 -> earliest token_start in cycle N+2.
- Requester rules: a requester drops req after gnt and must not change fields while req is high. Dropping req before gnt is legal and has no side effect.
- Fields are captured at grant only; later field changes do not alter the token in flight.
- eof_guard rising while in ISSUE/WAIT_DONE does not abort the current transaction; it only blocks the next grant.
- Back-to-back: return to IDLE is followed by a new grant no earlier than the next cycle, so at least one IDLE cycle separates transactions.

Optional Feature:
- Macro: USB_TOKEN_KBD_AGING_EN.
- Enabled: 4-bit kbd_age counter, reset 0.
  - Increments, saturating, on each grant to enum or trans while kbd_req=1.
  - When kbd_age>=AGE_LIMIT, kbd outranks trans but still loses to enum.
  - Clears to 0 on kbd grant.
- Disabled: no counter; strict priority enum > trans > kbd.

Test Plan:
- Reset: hold rst=1 for 2 cycles during WAIT_DONE -> all outputs 0, state IDLE, no token_start afterwards.
- Simultaneous request: enum, trans and kbd all request in the same cycle, with enum addr=0 endp=0 type=SETUP -> enum_gnt pulses 1 cycle, grant_id=1, token_start 1 cycle later carrying addr 0 / endp 0. After txn_done, trans is granted next, then kbd.
- Guard window: eof_guard=1 with kbd_req=1 for 50 cycles -> no gnt. Drop eof_guard -> kbd_gnt in the next cycle.
- Busy generator: token_busy=1 for 10 cycles after grant -> token_start delayed until the first cycle with token_busy=0, and exactly one pulse is issued.
- Timeout: TIMEOUT_CYCLES=8 and no txn_done -> timeout_err pulses 8 cycles after token_start, then IDLE. A second run with txn_done on that same cycle -> no timeout_err.
- Aging (macro on, AGE_LIMIT=4): trans_req and kbd_req both held; trans wins 4 consecutive grants -> 5th grant goes to kbd, kbd_age back to 0.
